// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM arbiter slice.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 1023;
    localparam int unsigned CNT_W           = 10;

    // Width of a requester index; kept at least 1 so NREQ=2 still gets a real bit.
    function automatic int unsigned grant_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant wins.
module rr_pick
    import dram_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned GW   = grant_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   last_grant,
    output logic [GW-1:0]   grant,
    output logic            any
);

    int unsigned     idx;
    logic [NREQ-1:0] rot;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        rot   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(last_grant) + i) % NREQ;
            rot = req >> idx;
            if (!any && rot[0]) begin
                any   = 1'b1;
                grant = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DRAM adapter port between NREQ requesters.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    reqRead,
    input  logic [NREQ-1:0]    reqWrite,
    input  logic [NREQ*32-1:0] reqAddress,
    input  logic [NREQ*32-1:0] reqWriteData,
    output logic [NREQ-1:0]    respValid,
    output logic [NREQ-1:0]    respError,
    output logic [31:0]        respReadData,
    output logic [31:0]        dramAddress,
    output logic [31:0]        dramWriteData,
    output logic               dramReadEnable,
    output logic               dramWriteEnable,
    input  logic [31:0]        dramReadData,
    input  logic               dramValid,
    output logic               busy
);

    localparam int unsigned     GW      = grant_width(NREQ);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       state;
    logic [GW-1:0]    grant_q;
    logic [GW-1:0]    last_q;
    logic [CNT_W-1:0] cnt;
    logic [GW-1:0]    pick_idx;
    logic             pick_any;

    rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
        .req        (reqRead | reqWrite),
        .last_grant (last_q),
        .grant      (pick_idx),
        .any        (pick_any)
    );

    assign busy = (state != IDLE);

    // The DRAM-facing registers double as the transaction latches: they are
    // loaded on the pick and cleared on leaving ISSUE, so they read 0 elsewhere.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            grant_q         <= '0;
            last_q          <= GW'(NREQ - 1);
            cnt             <= '0;
            dramAddress     <= '0;
            dramWriteData   <= '0;
            dramReadEnable  <= 1'b0;
            dramWriteEnable <= 1'b0;
            respValid       <= '0;
            respError       <= '0;
            respReadData    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_q         <= pick_idx;
                        dramAddress     <= reqAddress[32*pick_idx +: 32];
                        dramWriteData   <= reqWriteData[32*pick_idx +: 32];
                        dramWriteEnable <= reqWrite[pick_idx];
                        dramReadEnable  <= !reqWrite[pick_idx];
                        cnt             <= '0;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!dramValid) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (dramValid || cnt == TO_LAST) begin
                        if (dramValid) begin
                            respValid <= NREQ'(1) << grant_q;
                            if (dramReadEnable) begin
                                respReadData <= dramReadData;
                            end
                        end else begin
                            respError <= NREQ'(1) << grant_q;
                        end
                        dramAddress     <= '0;
                        dramWriteData   <= '0;
                        dramReadEnable  <= 1'b0;
                        dramWriteEnable <= 1'b0;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    respValid <= '0;
                    respError <= '0;
                    last_q    <= grant_q;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
